// File: rtl/sync_fifo_pkg.sv
// Shared constants, helpers and types for the flagged synchronous FIFO.
package sync_fifo_pkg;

  // Default geometry used when the FIFO is instantiated without overrides.
  localparam int unsigned DefWidth = 8;
  localparam int unsigned DefDepth = 16;

  // Read-mode encodings for the FWFT parameter.
  localparam int unsigned FIFO_STD  = 0;
  localparam int unsigned FIFO_FWFT = 1;

  // Fill counter needs one more bit than the pointers so it can represent DEPTH itself.
  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

  // Level flags, all derived from the fill count.
  typedef struct packed {
    logic wfull;
    logic rempty;
    logic almost_full;
    logic almost_empty;
  } fifo_flags_t;

endpackage

// File: rtl/sync_fifo_flags_dual_port_ram.sv
// Simple dual-port RAM: one synchronous write port, one registered read port, no reset.
module dual_port_ram #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     wen,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     ren,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Write port: store wdata at waddr on an enabled edge.
  always_ff @(posedge clk) begin
    if (wen) begin
      mem[waddr] <= wdata;
    end
  end

  // Read port: read-before-write; rdata holds when ren is low.
  always_ff @(posedge clk) begin
    if (ren) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/sync_fifo_flags.sv
// Synchronous FIFO with selectable read mode, fill count, programmable
// almost-full/almost-empty thresholds and overflow/underflow pulses.
module sync_fifo_flags
  import sync_fifo_pkg::*;
#(
  parameter int unsigned WIDTH    = DefWidth,
  parameter int unsigned DEPTH    = DefDepth,
  parameter int unsigned FWFT     = FIFO_STD,
  parameter int unsigned AF_LEVEL = DEPTH - 2,
  parameter int unsigned AE_LEVEL = 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        winc,
  input  logic [WIDTH-1:0]            wdata,
  input  logic                        rinc,
  output logic [WIDTH-1:0]            rdata,
  output logic                        wfull,
  output logic                        rempty,
  output logic                        almost_full,
  output logic                        almost_empty,
  output logic [cnt_width(DEPTH)-1:0] data_cnt,
  output logic                        wovf,
  output logic                        rudf
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = cnt_width(DEPTH);

  logic [AW-1:0]    wptr_q, wptr_d;
  logic [AW-1:0]    rptr_q, rptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  fifo_flags_t      flags_q, flags_d;
  logic             wovf_q, rudf_q;
  logic             wr_acc, rd_acc;

  // Read-path state: zero_q masks the un-reset RAM output register until it
  // holds real data; byp_q forwards a write that lands on the new head slot.
  logic             zero_q, zero_d;
  logic             byp_q, byp_d;
  logic [WIDTH-1:0] byp_data_q;

  logic             ram_ren;
  logic [AW-1:0]    ram_raddr;
  logic [WIDTH-1:0] ram_rdata;

  // Accept decisions, next pointers and next fill count.
  always_comb begin
    wr_acc = winc & ~flags_q.wfull;
    rd_acc = rinc & ~flags_q.rempty;
    wptr_d = wptr_q + AW'(wr_acc);
    rptr_d = rptr_q + AW'(rd_acc);
    cnt_d  = cnt_q;
    case ({wr_acc, rd_acc})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Flags are computed from the next count so they are exact right after the op.
  always_comb begin
    flags_d              = '0;
    flags_d.wfull        = (cnt_d == CW'(DEPTH));
    flags_d.rempty       = (cnt_d == '0);
    flags_d.almost_full  = (cnt_d >= CW'(AF_LEVEL));
    flags_d.almost_empty = (cnt_d <= CW'(AE_LEVEL));
  end

  // Read-port steering: FWFT prefetches the next head every cycle, standard
  // mode reads only on an accepted pop.
  always_comb begin
    ram_ren   = 1'b0;
    ram_raddr = rptr_q;
    byp_d     = 1'b0;
    zero_d    = zero_q;
    if (FWFT == FIFO_FWFT) begin
      ram_ren   = 1'b1;
      ram_raddr = rptr_d;
      // The RAM reads old contents when the new head is written this edge.
      byp_d     = wr_acc && (wptr_q == rptr_d);
      if (wr_acc) begin
        zero_d = 1'b0;
      end
    end else begin
      ram_ren   = rd_acc;
      ram_raddr = rptr_q;
      if (rd_acc) begin
        zero_d = 1'b0;
      end
    end
  end

  // Pointer, count, flag, pulse and read-path state with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      cnt_q      <= '0;
      flags_q    <= '{wfull: 1'b0, rempty: 1'b1, almost_full: 1'b0, almost_empty: 1'b1};
      wovf_q     <= 1'b0;
      rudf_q     <= 1'b0;
      zero_q     <= 1'b1;
      byp_q      <= 1'b0;
      byp_data_q <= '0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      cnt_q      <= cnt_d;
      flags_q    <= flags_d;
      wovf_q     <= winc & flags_q.wfull;
      rudf_q     <= rinc & flags_q.rempty;
      zero_q     <= zero_d;
      byp_q      <= byp_d;
      byp_data_q <= wdata;
    end
  end

  dual_port_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk   (clk),
    .wen   (wr_acc),
    .waddr (wptr_q),
    .wdata (wdata),
    .ren   (ram_ren),
    .raddr (ram_raddr),
    .rdata (ram_rdata)
  );

  // Output data: zero after reset, forwarded write on a head collision, else RAM.
  always_comb begin
    if (zero_q) begin
      rdata = '0;
    end else if (byp_q) begin
      rdata = byp_data_q;
    end else begin
      rdata = ram_rdata;
    end
  end

  assign wfull        = flags_q.wfull;
  assign rempty       = flags_q.rempty;
  assign almost_full  = flags_q.almost_full;
  assign almost_empty = flags_q.almost_empty;
  assign data_cnt     = cnt_q;
  assign wovf         = wovf_q;
  assign rudf         = rudf_q;

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Self-checking bench: a standard-read and an FWFT instance share stimulus and
// are compared against a queue-based model, a vector table and directed sequences.
module tb_sync_fifo_flags;
  import sync_fifo_pkg::*;

  localparam int unsigned W  = 8;
  localparam int unsigned D  = 16;
  localparam int unsigned AF = 14;
  localparam int unsigned AE = 2;
  localparam int unsigned CW = 5;

  logic          clk;
  logic          rst_n, winc, rinc;
  logic [W-1:0]  wdata;
  logic [W-1:0]  rdata0, rdata1;
  logic          wfull0, rempty0, af0, ae0, wovf0, rudf0;
  logic          wfull1, rempty1, af1, ae1, wovf1, rudf1;
  logic [CW-1:0] cnt0, cnt1;

  int n_pass  = 0;
  int n_total = 0;

  // Reference model: the FIFO contents as a queue, plus the last popped value.
  logic [W-1:0] mq [$];
  logic [W-1:0] m_last;
  logic         m_ovf, m_udf;

  sync_fifo_flags #(
    .WIDTH(W), .DEPTH(D), .FWFT(FIFO_STD), .AF_LEVEL(AF), .AE_LEVEL(AE)
  ) u_std (
    .clk(clk), .rst_n(rst_n), .winc(winc), .wdata(wdata), .rinc(rinc), .rdata(rdata0),
    .wfull(wfull0), .rempty(rempty0), .almost_full(af0), .almost_empty(ae0),
    .data_cnt(cnt0), .wovf(wovf0), .rudf(rudf0)
  );

  sync_fifo_flags #(
    .WIDTH(W), .DEPTH(D), .FWFT(FIFO_FWFT), .AF_LEVEL(AF), .AE_LEVEL(AE)
  ) u_fwft (
    .clk(clk), .rst_n(rst_n), .winc(winc), .wdata(wdata), .rinc(rinc), .rdata(rdata1),
    .wfull(wfull1), .rempty(rempty1), .almost_full(af1), .almost_empty(ae1),
    .data_cnt(cnt1), .wovf(wovf1), .rudf(rudf1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
  endtask

  task automatic model_step();
    bit full, empty;
    if (!rst_n) begin
      mq.delete();
      m_last = '0;
      m_ovf  = 1'b0;
      m_udf  = 1'b0;
    end else begin
      full  = (mq.size() == D);
      empty = (mq.size() == 0);
      m_ovf = winc && full;
      m_udf = rinc && empty;
      if (rinc && !empty) m_last = mq.pop_front();
      if (winc && !full) mq.push_back(wdata);
    end
  endtask

  task automatic check_model();
    int n;
    n = mq.size();
    chk("std_cnt",     32'(cnt0), n);
    chk("std_rempty",  32'(rempty0), 32'(n == 0));
    chk("std_wfull",   32'(wfull0), 32'(n == D));
    chk("std_afull",   32'(af0), 32'(n >= AF));
    chk("std_aempty",  32'(ae0), 32'(n <= AE));
    chk("std_wovf",    32'(wovf0), 32'(m_ovf));
    chk("std_rudf",    32'(rudf0), 32'(m_udf));
    chk("std_rdata",   32'(rdata0), 32'(m_last));
    chk("fwft_cnt",    32'(cnt1), n);
    chk("fwft_rempty", 32'(rempty1), 32'(n == 0));
    chk("fwft_wfull",  32'(wfull1), 32'(n == D));
    chk("fwft_afull",  32'(af1), 32'(n >= AF));
    chk("fwft_aempty", 32'(ae1), 32'(n <= AE));
    chk("fwft_wovf",   32'(wovf1), 32'(m_ovf));
    chk("fwft_rudf",   32'(rudf1), 32'(m_udf));
    if (n > 0) chk("fwft_head", 32'(rdata1), 32'(mq[0]));
  endtask

  // Drive one cycle's inputs at the falling edge, clock them in, check at the next fall.
  task automatic cycle(input logic r, input logic w, input logic [W-1:0] wd, input logic rd);
    rst_n = r;
    winc  = w;
    wdata = wd;
    rinc  = rd;
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_model();
  endtask

  typedef struct {
    logic         rst_n, winc, rinc;
    logic [W-1:0] wdata;
    int           exp_cnt;
    logic         exp_empty, exp_full, exp_udf;
    logic [W-1:0] exp_rd;
    logic         head_chk;
    logic [W-1:0] exp_head;
  } vec_t;

  vec_t vt [10];
  int   wbias, rbias;

  initial begin
    vt[0] = '{1'b0, 1'b0, 1'b0, 8'h00, 0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00};
    vt[1] = '{1'b1, 1'b0, 1'b1, 8'h00, 0, 1'b1, 1'b0, 1'b1, 8'h00, 1'b0, 8'h00};
    vt[2] = '{1'b1, 1'b1, 1'b0, 8'h11, 1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 8'h11};
    vt[3] = '{1'b1, 1'b1, 1'b0, 8'h22, 2, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 8'h11};
    vt[4] = '{1'b1, 1'b1, 1'b1, 8'h33, 2, 1'b0, 1'b0, 1'b0, 8'h11, 1'b1, 8'h22};
    vt[5] = '{1'b1, 1'b0, 1'b1, 8'h00, 1, 1'b0, 1'b0, 1'b0, 8'h22, 1'b1, 8'h33};
    vt[6] = '{1'b1, 1'b0, 1'b1, 8'h00, 0, 1'b1, 1'b0, 1'b0, 8'h33, 1'b0, 8'h00};
    vt[7] = '{1'b1, 1'b0, 1'b1, 8'h00, 0, 1'b1, 1'b0, 1'b1, 8'h33, 1'b0, 8'h00};
    vt[8] = '{1'b1, 1'b1, 1'b1, 8'h44, 1, 1'b0, 1'b0, 1'b1, 8'h33, 1'b1, 8'h44};
    vt[9] = '{1'b1, 1'b0, 1'b1, 8'h00, 0, 1'b1, 1'b0, 1'b0, 8'h44, 1'b0, 8'h00};

    rst_n = 1'b0;
    winc  = 1'b0;
    rinc  = 1'b0;
    wdata = '0;
    @(negedge clk);

    // Vector table.
    for (int i = 0; i < 10; i++) begin
      cycle(vt[i].rst_n, vt[i].winc, vt[i].wdata, vt[i].rinc);
      chk($sformatf("v%0d_cnt", i), 32'(cnt0), vt[i].exp_cnt);
      chk($sformatf("v%0d_empty", i), 32'(rempty0), 32'(vt[i].exp_empty));
      chk($sformatf("v%0d_full", i), 32'(wfull0), 32'(vt[i].exp_full));
      chk($sformatf("v%0d_udf", i), 32'(rudf0), 32'(vt[i].exp_udf));
      chk($sformatf("v%0d_rdata", i), 32'(rdata0), 32'(vt[i].exp_rd));
      if (vt[i].head_chk) chk($sformatf("v%0d_head", i), 32'(rdata1), 32'(vt[i].exp_head));
    end

    // Reset then idle, and fill to full with threshold crossings.
    cycle(1'b0, 1'b0, 8'h00, 1'b0);
    cycle(1'b1, 1'b0, 8'h00, 1'b0);
    chk("idle_aempty", 32'(ae0), 1);
    chk("idle_rdata", 32'(rdata0), 0);
    for (int i = 1; i <= 16; i++) begin
      cycle(1'b1, 1'b1, 8'(i), 1'b0);
      if (i == 2)  chk("ae_after2", 32'(ae0), 1);
      if (i == 3)  chk("ae_after3", 32'(ae0), 0);
      if (i == 13) chk("af_after13", 32'(af0), 0);
      if (i == 14) chk("af_after14", 32'(af0), 1);
      if (i == 15) chk("full_after15", 32'(wfull0), 0);
      if (i == 16) chk("full_after16", 32'(wfull0), 1);
      if (i == 16) chk("cnt_after16", 32'(cnt0), 16);
    end
    cycle(1'b1, 1'b1, 8'hEE, 1'b0);
    chk("ovf_pulse", 32'(wovf0), 1);
    chk("ovf_cnt", 32'(cnt0), 16);
    cycle(1'b1, 1'b0, 8'h00, 1'b0);
    chk("ovf_drop", 32'(wovf0), 0);

    // Drain from full in order, then underflow.
    for (int i = 1; i <= 16; i++) begin
      cycle(1'b1, 1'b0, 8'h00, 1'b1);
      chk($sformatf("drain_%0d", i), 32'(rdata0), i);
    end
    chk("drain_empty", 32'(rempty0), 1);
    cycle(1'b1, 1'b0, 8'h00, 1'b1);
    chk("udf_pulse", 32'(rudf0), 1);
    chk("udf_hold", 32'(rdata0), 16);
    cycle(1'b1, 1'b0, 8'h00, 1'b0);
    chk("udf_drop", 32'(rudf0), 0);

    // Simultaneous write+read at count 5.
    for (int i = 1; i <= 5; i++) cycle(1'b1, 1'b1, 8'(8'h50 + i), 1'b0);
    cycle(1'b1, 1'b1, 8'h56, 1'b1);
    chk("sim5_cnt", 32'(cnt0), 5);
    chk("sim5_rdata", 32'(rdata0), 32'h51);
    for (int i = 2; i <= 6; i++) begin
      cycle(1'b1, 1'b0, 8'h00, 1'b1);
      chk($sformatf("sim5_order_%0d", i), 32'(rdata0), 32'h50 + i);
    end

    // Simultaneous at full: read only.
    for (int i = 0; i < 16; i++) cycle(1'b1, 1'b1, 8'(8'h60 + i), 1'b0);
    cycle(1'b1, 1'b1, 8'hFF, 1'b1);
    chk("simfull_cnt", 32'(cnt0), 15);
    chk("simfull_ovf", 32'(wovf0), 1);
    chk("simfull_rdata", 32'(rdata0), 32'h60);
    for (int i = 0; i < 15; i++) cycle(1'b1, 1'b0, 8'h00, 1'b1);

    // Simultaneous at empty: write only.
    cycle(1'b1, 1'b1, 8'h77, 1'b1);
    chk("simempty_cnt", 32'(cnt0), 1);
    chk("simempty_udf", 32'(rudf0), 1);
    cycle(1'b1, 1'b0, 8'h00, 1'b1);
    chk("simempty_rdata", 32'(rdata0), 32'h77);

    // Wrap-around across the pointer boundary.
    cycle(1'b0, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 10; i++) cycle(1'b1, 1'b1, 8'(i), 1'b0);
    for (int i = 0; i < 10; i++) cycle(1'b1, 1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 12; i++) cycle(1'b1, 1'b1, 8'(8'hA0 + i), 1'b0);
    for (int i = 0; i < 12; i++) begin
      cycle(1'b1, 1'b0, 8'h00, 1'b1);
      chk($sformatf("wrap_%0d", i), 32'(rdata0), 32'hA0 + i);
    end

    // Reset mid-operation discards data.
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b1, 8'(8'hC0 + i), 1'b0);
    cycle(1'b0, 1'b0, 8'h00, 1'b0);
    chk("midrst_cnt", 32'(cnt0), 0);
    chk("midrst_empty", 32'(rempty0), 1);
    cycle(1'b1, 1'b0, 8'h00, 1'b1);
    chk("midrst_udf", 32'(rudf0), 1);
    chk("midrst_rdata", 32'(rdata0), 0);

    // FWFT fall-through.
    cycle(1'b1, 1'b1, 8'h55, 1'b0);
    chk("fwft_empty_drop", 32'(rempty1), 0);
    chk("fwft_55", 32'(rdata1), 32'h55);
    cycle(1'b1, 1'b1, 8'h66, 1'b0);
    chk("fwft_55_hold", 32'(rdata1), 32'h55);
    cycle(1'b1, 1'b0, 8'h00, 1'b1);
    chk("fwft_66", 32'(rdata1), 32'h66);
    cycle(1'b1, 1'b0, 8'h00, 1'b1);
    chk("fwft_empty", 32'(rempty1), 1);

    // Randomized traffic with shifting write/read bias and rare resets.
    for (int blk = 0; blk < 6; blk++) begin
      wbias = 20 + 12 * blk;
      rbias = 80 - 12 * blk;
      for (int i = 0; i < 500; i++) begin
        cycle(($urandom_range(0, 255) != 0),
              ($urandom_range(0, 99) < wbias),
              8'($urandom),
              ($urandom_range(0, 99) < rbias));
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
